// File: rtl/puzzle_move_sequencer.sv
// puzzle_move_sequencer: loads a start board and steps the 8-puzzle ALU through a
// handshaked move stream. Define PMS_MOVE_LIMIT_EN to end a run after MAX_MOVES moves.
module puzzle_move_sequencer #(
    parameter int MCW       = 8,
    parameter int MAX_MOVES = 200
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [39:0]     start_board,
    input  logic [39:0]     goal_board,
    input  logic            mv_valid,
    output logic            mv_ready,
    input  logic [1:0]      mv_dir,
    input  logic            mv_last,
    output logic [3:0]      alu_op,
    output logic [39:0]     alu_in0,
    output logic [39:0]     alu_in1,
    input  logic [39:0]     alu_out,
    input  logic            alu_zf,
    output logic [39:0]     board,
    output logic [MCW-1:0]  move_count,
    output logic            busy,
    output logic            done,
    output logic            solved,
    output logic            illegal,
    output logic            limit_hit
);

    localparam logic [3:0] OP_COPY        = 4'd0;
    localparam logic [3:0] OP_COMP        = 4'd1;
    localparam logic [3:0] OP_POSSIBLE_UP = 4'd2;
    localparam logic [3:0] OP_TO_UP       = 4'd6;

`ifdef PMS_MOVE_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMP,
        S_WAIT_MV,
        S_CHECK,
        S_APPLY,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [39:0]     r_board;
    logic [MCW-1:0]  r_count;
    logic            r_solved;
    logic            r_illegal;
    logic            r_limit;
    logic [1:0]      r_dir;
    logic            r_last;
    logic            w_at_limit;

    assign w_at_limit = LIMIT_EN && (r_count == MCW'(MAX_MOVES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Solved outranks the move limit, which outranks the last-move marker.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_COMP;
            S_COMP: begin
                if (alu_zf)          w_next = S_DONE;
                else if (w_at_limit) w_next = S_DONE;
                else if (r_last)     w_next = S_DONE;
                else                 w_next = S_WAIT_MV;
            end
            S_WAIT_MV: if (mv_valid) w_next = S_CHECK;
            S_CHECK:   w_next = alu_zf ? S_APPLY : S_DONE;
            S_APPLY:   w_next = S_COMP;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        alu_op   = OP_COPY;
        alu_in0  = r_board;
        alu_in1  = r_board;
        mv_ready = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_COMP: begin
                alu_op  = OP_COMP;
                alu_in1 = goal_board;
            end
            S_WAIT_MV: mv_ready = 1'b1;
            S_CHECK:   alu_op   = OP_POSSIBLE_UP + {2'b00, r_dir};
            S_APPLY:   alu_op   = OP_TO_UP + {2'b00, r_dir};
            S_DONE:    done     = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_board   <= '0;
            r_count   <= '0;
            r_solved  <= 1'b0;
            r_illegal <= 1'b0;
            r_limit   <= 1'b0;
            r_dir     <= '0;
            r_last    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_board   <= start_board;
                        r_count   <= '0;
                        r_solved  <= 1'b0;
                        r_illegal <= 1'b0;
                        r_limit   <= 1'b0;
                        r_last    <= 1'b0;
                    end
                end
                S_COMP: begin
                    if (alu_zf)          r_solved <= 1'b1;
                    else if (w_at_limit) r_limit  <= 1'b1;
                end
                S_WAIT_MV: begin
                    if (mv_valid) begin
                        r_dir  <= mv_dir;
                        r_last <= mv_last;
                    end
                end
                S_CHECK: if (!alu_zf) r_illegal <= 1'b1;
                S_APPLY: begin
                    r_board <= alu_out;
                    if (r_count != '1) r_count <= r_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign board      = r_board;
    assign move_count = r_count;
    assign busy       = (r_state != S_IDLE);
    assign solved     = r_solved;
    assign illegal    = r_illegal;
    assign limit_hit  = LIMIT_EN ? r_limit : 1'b0;

endmodule

// File: tb/tb_puzzle_move_sequencer.sv
// Bench for puzzle_move_sequencer: 8-puzzle ALU model, board-level reference model,
// cycle-by-cycle expectation queue derived from the stated latencies, random runs.
module tb_puzzle_move_sequencer;

    localparam int MCW    = 8;
    localparam int TB_MAX = 2;
`ifdef PMS_MOVE_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    localparam logic [39:0] GOAL = 40'h8123456780;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [39:0]     start_board;
    logic [39:0]     goal_board;
    logic            mv_valid;
    logic            mv_ready;
    logic [1:0]      mv_dir;
    logic            mv_last;
    logic [3:0]      alu_op;
    logic [39:0]     alu_in0;
    logic [39:0]     alu_in1;
    logic [39:0]     alu_out;
    logic            alu_zf;
    logic [39:0]     board;
    logic [MCW-1:0]  move_count;
    logic            busy;
    logic            done;
    logic            solved;
    logic            illegal;
    logic            limit_hit;

    puzzle_move_sequencer #(.MCW(MCW), .MAX_MOVES(TB_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_board(start_board),
        .goal_board(goal_board), .mv_valid(mv_valid), .mv_ready(mv_ready),
        .mv_dir(mv_dir), .mv_last(mv_last), .alu_op(alu_op), .alu_in0(alu_in0),
        .alu_in1(alu_in1), .alu_out(alu_out), .alu_zf(alu_zf), .board(board),
        .move_count(move_count), .busy(busy), .done(done), .solved(solved),
        .illegal(illegal), .limit_hit(limit_hit)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Grid geometry: blank moves up/down by 3 positions, left/right by 1 within a row.
    function automatic int target(input logic [39:0] b, input logic [1:0] d);
        int p;
        p = int'(b[39:36]);
        if (p > 8) return -1;
        case (d)
            2'd0:    return (p / 3 > 0) ? p - 3 : -1;
            2'd1:    return (p / 3 < 2) ? p + 3 : -1;
            2'd2:    return (p % 3 < 2) ? p + 1 : -1;
            default: return (p % 3 > 0) ? p - 1 : -1;
        endcase
    endfunction

    function automatic logic [39:0] do_move(input logic [39:0] b, input logic [1:0] d);
        logic [3:0]  t[9];
        logic [3:0]  tmp;
        logic [39:0] r;
        int p, q;
        q = target(b, d);
        if (q < 0) return b;
        p = int'(b[39:36]);
        for (int k = 0; k < 9; k++) t[k] = b[35-4*k -: 4];
        tmp = t[p]; t[p] = t[q]; t[q] = tmp;
        r[39:36] = 4'(q);
        for (int k = 0; k < 9; k++) r[35-4*k -: 4] = t[k];
        return r;
    endfunction

    always_comb begin
        alu_out = alu_in0;
        alu_zf  = 1'b0;
        if (alu_op == 4'd1) begin
            alu_zf = (alu_in0 == alu_in1);
        end else if (alu_op >= 4'd2 && alu_op <= 4'd5) begin
            alu_zf = (target(alu_in0, 2'(alu_op - 4'd2)) >= 0);
        end else if (alu_op >= 4'd6 && alu_op <= 4'd9) begin
            alu_out = do_move(alu_in1, 2'(alu_op - 4'd6));
        end
    end

    typedef struct packed {
        logic           rdy;
        logic           dn;
        logic           bsy;
        logic           sol;
        logic           ill;
        logic           lim;
        logic [39:0]    brd;
        logic [MCW-1:0] cnt;
    } exp_t;

    exp_t           exp_q[$];
    logic [39:0]    m_board = '0;
    logic [MCW-1:0] m_cnt   = '0;
    logic           m_sol   = 1'b0;
    logic           m_ill   = 1'b0;
    logic           m_lim   = 1'b0;
    logic [1:0]     g_mv[$];
    logic           g_last;

    function automatic exp_t mk(input logic r, input logic dn, input logic b);
        exp_t e;
        e.rdy = r;     e.dn  = dn;    e.bsy = b;
        e.sol = m_sol; e.ill = m_ill; e.lim = m_lim;
        e.brd = m_board; e.cnt = m_cnt;
        return e;
    endfunction

    always @(negedge clk) begin : compare
        exp_t ce;
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("mv_ready",   64'(mv_ready),   64'(ce.rdy));
            chk("done",       64'(done),       64'(ce.dn));
            chk("busy",       64'(busy),       64'(ce.bsy));
            chk("solved",     64'(solved),     64'(ce.sol));
            chk("illegal",    64'(illegal),    64'(ce.ill));
            chk("limit_hit",  64'(limit_hit),  64'(ce.lim));
            chk("board",      64'(board),      64'(ce.brd));
            chk("move_count", 64'(move_count), 64'(ce.cnt));
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [39:0] rand_board();
        logic [3:0]  t[9];
        logic [3:0]  tmp;
        logic [39:0] b;
        int j, bl;
        bl = 0;
        for (int k = 0; k < 9; k++) t[k] = 4'(k);
        for (int k = 8; k > 0; k--) begin
            j = $urandom_range(0, k);
            tmp = t[k]; t[k] = t[j]; t[j] = tmp;
        end
        for (int k = 0; k < 9; k++) begin
            b[35-4*k -: 4] = t[k];
            if (t[k] == 4'd0) bl = k;
        end
        b[39:36] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'(bl);
        return b;
    endfunction

    // One cycle: inputs applied just after the edge, expectation checked on the falling edge.
    task automatic cyc(input logic st, input logic [39:0] sb, input logic v,
                       input logic [1:0] d, input logic l, input exp_t e);
        @(posedge clk); #1;
        start = st; start_board = sb; mv_valid = v; mv_dir = d; mv_last = l;
        exp_q.push_back(e);
    endtask

    task automatic jcyc(input exp_t e);
        cyc(($urandom_range(0, 3) == 0), 40'({$urandom(), $urandom()}), rb(),
            2'($urandom_range(0, 3)), rb(), e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        start = 1'b0; mv_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_board", 64'(board), 64'(0));
        chk("rst_count", 64'(move_count), 64'(0));
        chk("rst_busy",  64'(busy), 64'(0));
        chk("rst_ready", 64'(mv_ready), 64'(0));
        chk("rst_flags", 64'({done, solved, illegal, limit_hit}), 64'(0));
        chk("rst_alu",   64'({alu_op, alu_in0, alu_in1}), 64'(0));
        @(negedge clk); #1;
        rst_n = 1'b1;
        m_board = '0; m_cnt = '0; m_sol = 1'b0; m_ill = 1'b0; m_lim = 1'b0;
    endtask

    // Plays one run from g_mv/g_last; rst_apply = index of the move whose APPLY cycle is reset.
    task automatic run(input logic [39:0] sb, input logic [39:0] gb, input int rst_apply);
        logic       lastf;
        logic       pre;
        logic [1:0] dir;
        int         i, d;
        goal_board = gb;
        cyc(1'b1, sb, rb(), 2'($urandom_range(0, 3)), rb(), mk(1'b0, 1'b0, 1'b0));
        m_board = sb; m_cnt = '0; m_sol = 1'b0; m_ill = 1'b0; m_lim = 1'b0;
        lastf = 1'b0; i = 0;
        forever begin
            if (m_board == gb) begin
                jcyc(mk(1'b0, 1'b0, 1'b1));
                m_sol = 1'b1;
                jcyc(mk(1'b0, 1'b1, 1'b1));
                break;
            end
            if (LIM && m_cnt == MCW'(TB_MAX)) begin
                jcyc(mk(1'b0, 1'b0, 1'b1));
                m_lim = 1'b1;
                jcyc(mk(1'b0, 1'b1, 1'b1));
                break;
            end
            if (lastf) begin
                jcyc(mk(1'b0, 1'b0, 1'b1));
                jcyc(mk(1'b0, 1'b1, 1'b1));
                break;
            end
            pre = (i < g_mv.size()) && rb();
            cyc(($urandom_range(0, 3) == 0), 40'({$urandom(), $urandom()}), pre,
                pre ? g_mv[i] : 2'd0, pre && g_last && (i == g_mv.size() - 1),
                mk(1'b0, 1'b0, 1'b1));
            if (i >= g_mv.size()) begin
                do_reset();
                break;
            end
            dir   = g_mv[i];
            lastf = g_last && (i == g_mv.size() - 1);
            d = pre ? 0 : $urandom_range(0, 3);
            repeat (d) cyc(rb(), 40'({$urandom(), $urandom()}), 1'b0, 2'($urandom_range(0, 3)),
                           rb(), mk(1'b1, 1'b0, 1'b1));
            cyc(rb(), 40'({$urandom(), $urandom()}), 1'b1, dir, lastf, mk(1'b1, 1'b0, 1'b1));
            jcyc(mk(1'b0, 1'b0, 1'b1));
            if (target(m_board, dir) < 0) begin
                m_ill = 1'b1;
                jcyc(mk(1'b0, 1'b1, 1'b1));
                break;
            end
            if (rst_apply == i) begin
                do_reset();
                break;
            end
            jcyc(mk(1'b0, 1'b0, 1'b1));
            m_board = do_move(m_board, dir);
            if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
            i++;
        end
        mv_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    function automatic logic [1:0] pick(input logic [39:0] b);
        logic [1:0] d;
        d = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) begin
            for (int k = 0; k < 8; k++) begin
                if (target(b, d) >= 0) break;
                d = 2'($urandom_range(0, 3));
            end
        end
        return d;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [39:0] sb, gb, pb;
        int          n, gj;
        logic        from_path;
        logic [1:0]  dd;

        rst_n = 1'b0; start = 1'b0; start_board = '0; goal_board = '0;
        mv_valid = 1'b0; mv_dir = '0; mv_last = 1'b0;

        chk("model_down",    do_move(40'h5123450786, 2'd1), 40'h8123456780);
        chk("model_up",      do_move(40'h8123456780, 2'd0), 40'h5123450786);
        chk("model_left",    do_move(40'h8123456780, 2'd3), 40'h7123456708);
        chk("model_illegal", 64'(target(40'h8123456780, 2'd1) < 0), 64'(1));
        chk("model_blank9",  64'(target(40'h9123456780, 2'd0) < 0), 64'(1));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_board", 64'(board), 64'(0));
        chk("reset_state", 64'({busy, done, mv_ready, solved, illegal, limit_hit, move_count}), 64'(0));
        @(negedge clk); #1;
        rst_n = 1'b1;

        g_mv.delete(); g_last = 1'b1;
        run(GOAL, GOAL, -1);
        settle();
        chk("t1_solved", 64'(solved), 64'(1));
        chk("t1_count",  64'(move_count), 64'(0));

        g_mv.delete(); g_mv.push_back(2'd1); g_last = 1'b1;
        run(40'h5123450786, GOAL, -1);
        settle();
        chk("t2_board",  64'(board), 64'h8123456780);
        chk("t2_solved", 64'(solved), 64'(1));
        chk("t2_count",  64'(move_count), 64'(1));

        g_mv.delete(); g_mv.push_back(2'd1); g_last = 1'b1;
        run(GOAL, 40'h0123456789, -1);
        settle();
        chk("t3_illegal", 64'(illegal), 64'(1));
        chk("t3_board",   64'(board), 64'h8123456780);
        chk("t3_count",   64'(move_count), 64'(0));

        g_mv.delete();
        for (int k = 0; k < 4; k++) g_mv.push_back((k % 2 == 0) ? 2'd0 : 2'd1);
        g_last = 1'b1;
        run(GOAL, 40'h0123456789, -1);
        settle();
        chk("t4_count", 64'(move_count), LIM ? 64'(2) : 64'(4));
        chk("t4_flags", 64'({solved, illegal, limit_hit}), LIM ? 64'(1) : 64'(0));

        g_mv.delete(); g_mv.push_back(2'd0); g_mv.push_back(2'd1); g_last = 1'b0;
        run(GOAL, 40'h0123456789, 0);
        settle();

        g_mv.delete();
        for (int k = 0; k < 6; k++) g_mv.push_back((k % 2 == 0) ? 2'd0 : 2'd1);
        g_last = 1'b0;
        run(GOAL, 40'h0123456789, -1);
        settle();

        g_mv.delete();
        for (int k = 0; k < 260; k++) g_mv.push_back((k % 2 == 0) ? 2'd0 : 2'd1);
        g_last = 1'b1;
        run(GOAL, 40'h0123456789, -1);
        settle();
        chk("sat_count", 64'(move_count), LIM ? 64'(2) : 64'(255));

        for (int r = 0; r < 40; r++) begin
            sb = rand_board();
            gb = rand_board();
            n  = $urandom_range(1, 6);
            gj = $urandom_range(0, n);
            from_path = ($urandom_range(0, 2) == 0);
            if (from_path && gj == 0) gb = sb;
            pb = sb;
            g_mv.delete();
            for (int k = 0; k < n; k++) begin
                dd = pick(pb);
                g_mv.push_back(dd);
                pb = do_move(pb, dd);
                if (from_path && k + 1 == gj) gb = pb;
            end
            g_last = ($urandom_range(0, 4) != 0);
            run(sb, gb, -1);
        end

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
